sync_fifo_ctrl: RTL

Single-clock, first-word-fall-through FIFO built around one DualPortRam instance. It sits directly upstream of the RAM and drives its write and read ports. It converts a valid/ready producer stream into RAM writes, then prefetches RAM reads so the RAM's registered RData serves as the FIFO output stage. It is the standard buffering element between Balotelli pipeline stages that need more than a skid register.

---
 rtl/sync_fifo_ctrl_pkg.sv | 12 +
 rtl/sync_fifo_ctrl_dual_port_ram.sv | 35 +++
 rtl/sync_fifo_ctrl.sv | 89 ++++++++
 3 files changed

// File: rtl/sync_fifo_ctrl_pkg.sv
// rtl/sync_fifo_ctrl_pkg.sv - shared defaults and sizing helper for the FWFT FIFO
package sync_fifo_ctrl_pkg;

    localparam int DEFAULT_DATA_WIDTH = 64;
    localparam int DEFAULT_DEEPTH     = 16;

    // Pointer width: RAM address bits plus one wrap bit.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_ctrl_dual_port_ram.sv
// rtl/sync_fifo_ctrl_dual_port_ram.sv - simple dual-port RAM with registered read data
module DualPortRam
    import sync_fifo_ctrl_pkg::*;
#(
    parameter int DataWidth = DEFAULT_DATA_WIDTH,
    parameter int Deepth    = DEFAULT_DEEPTH
) (
    input  logic                      WClk,
    input  logic                      WEnc,
    input  logic [$clog2(Deepth)-1:0] WAddr,
    input  logic [DataWidth-1:0]      WData,
    input  logic                      RClk,
    input  logic                      REnc,
    input  logic [$clog2(Deepth)-1:0] RAddr,
    output logic [DataWidth-1:0]      RData,
    input  logic                      Ground
);

    logic [DataWidth-1:0] mem [Deepth];

    // Write port; Ground high idles both ports (the FIFO ties it low).
    always_ff @(posedge WClk) begin
        if (WEnc && !Ground) begin
            mem[WAddr] <= WData;
        end
    end

    // Read port; RData only changes on an enabled read, so it acts as a holding register.
    always_ff @(posedge RClk) begin
        if (REnc && !Ground) begin
            RData <= mem[RAddr];
        end
    end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// rtl/sync_fifo_ctrl.sv - first-word-fall-through FIFO controller around DualPortRam
module sync_fifo_ctrl
    import sync_fifo_ctrl_pkg::*;
#(
    parameter int DataWidth = DEFAULT_DATA_WIDTH,
    parameter int Deepth    = DEFAULT_DEEPTH
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic [DataWidth-1:0]    InData,
    input  logic                    InValid,
    output logic                    InReady,
    output logic [DataWidth-1:0]    OutData,
    output logic                    OutValid,
    input  logic                    OutReady,
    output logic [$clog2(Deepth):0] Count
);

    localparam int AddrWidth = $clog2(Deepth);
    localparam int PtrWidth  = ptr_width(Deepth);

    logic [PtrWidth-1:0]  wr_ptr;
    logic [PtrWidth-1:0]  rd_ptr;
    logic [PtrWidth-1:0]  ram_count;
    logic                 push;
    logic                 pop;
    logic                 fetch;
    logic [AddrWidth-1:0] waddr;
    logic [AddrWidth-1:0] raddr;

    // Occupancy of the RAM alone; the wrap bit makes the subtraction exact modulo 2*Deepth.
    assign ram_count = wr_ptr - rd_ptr;

    // Ready depends only on registered pointers, never on InValid or OutReady.
    assign InReady = (ram_count != PtrWidth'(Deepth));

    assign push  = InValid && InReady;
    assign pop   = OutValid && OutReady;
    // Prefetch into the RData stage whenever it is empty or being drained this cycle.
    assign fetch = (ram_count != '0) && (!OutValid || OutReady);

    assign waddr = wr_ptr[AddrWidth-1:0];
    assign raddr = rd_ptr[AddrWidth-1:0];

    // Pointers advance by one per push/fetch and wrap through the extra MSB.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (fetch) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Output stage valid: a fetch refills it, a pop without a refill empties it.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            OutValid <= 1'b0;
        end else if (fetch) begin
            OutValid <= 1'b1;
        end else if (pop) begin
            OutValid <= 1'b0;
        end
    end

    assign Count = ram_count + PtrWidth'(OutValid);

    // Read and write addresses cannot collide: equal low bits mean empty (no fetch) or full (no push).
    DualPortRam #(
        .DataWidth (DataWidth),
        .Deepth    (Deepth)
    ) u_ram (
        .WClk   (Clk),
        .WEnc   (push),
        .WAddr  (waddr),
        .WData  (InData),
        .RClk   (Clk),
        .REnc   (fetch),
        .RAddr  (raddr),
        .RData  (OutData),
        .Ground (1'b0)
    );

endmodule
